jt12_wr_arb: RTL and testbench

- Arbitrates and sequences CPU-side register writes to the jt12 core.
- Two independent requesters share the core's cs_n/wr_n/addr/din bus, for example a 68000-side and a Z80-side write queue, or a stimulus player plus a host.
- Each granted request becomes a full YM2612 transaction: busy poll, address write, busy poll, value write.
- Busy is taken from core status bit 7.

---
 rtl/jt12_wr_arb.sv | 203 ++++++++++++++++++++
 tb/tb_jt12_wr_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_wr_arb.sv
// jt12_wr_arb: two-requester write arbiter/sequencer for the jt12 bus.
// Each grant runs: busy poll, address strobe, busy poll, value strobe.
//
// Ports:
//   rst, clk         sync active-high reset, rising-edge clock
//   reqN/partN/regN/valN  requester N write (N=0,1), held until ackN
//   ackN             one-cycle pulse when requester N's write is done
//   cs_n, wr_n       core chip select / write strobe, active-low
//   addr, dout       core address {part,a0} and data
//   din              core status, din[7] = busy
//   gnt              current/last granted requester
//   err              sticky busy-timeout flag
// Optional: define JT12_ARB_TIMEOUT_EN to bound each busy poll to
// TMO cycles; without it polls wait forever and err is tied low.

module jt12_wr_arb #(
  parameter int WR_CYC = 2,
  parameter int GAP    = 1,
  parameter int TMO    = 1023
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       req0,
  input  logic       part0,
  input  logic [7:0] reg0,
  input  logic [7:0] val0,
  output logic       ack0,
  input  logic       req1,
  input  logic       part1,
  input  logic [7:0] reg1,
  input  logic [7:0] val1,
  output logic       ack1,
  output logic       cs_n,
  output logic       wr_n,
  output logic [1:0] addr,
  output logic [7:0] dout,
  input  logic [7:0] din,
  output logic       gnt,
  output logic       err
);

  if (WR_CYC < 1 || WR_CYC > 15 || GAP < 0 || GAP > 15 || TMO < 1)
  begin : g_bad_param
    $error("jt12_wr_arb: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    POLL_A,
    STRB_A,
    HOLD_A,
    POLL_V,
    STRB_V,
    HOLD_V,
    ACK
  } state_t;

  localparam logic [3:0] STRB_LAST = 4'(WR_CYC - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       part_q, part_nx;
  logic [7:0] reg_q, reg_nx;
  logic [7:0] val_q, val_nx;
  logic       gnt_nx;
  logic       cs_nx, wr_nx;
  logic [1:0] addr_nx;
  logic [7:0] dout_nx;
  logic       sel, sel_part;
  logic       polling, poll_go;
  logic       din_unused;

  // Both requesting: take the one not served last.
  assign sel      = (req0 && req1) ? ~gnt : req1;
  assign sel_part = sel ? part1 : part0;
  assign polling  = (state == POLL_A) || (state == POLL_V);
  assign din_unused = ^din[6:0];

`ifdef JT12_ARB_TIMEOUT_EN
  localparam int PW = $clog2(TMO + 1);
  localparam logic [PW-1:0] TMO_LAST = PW'(TMO - 1);

  logic [PW-1:0] pcnt;
  logic          tmo_hit;

  assign tmo_hit = din[7] && (pcnt == TMO_LAST);
  assign poll_go = !din[7] || tmo_hit;

  // Counter rests at zero outside polls, so every poll starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (polling && !poll_go) pcnt <= pcnt + 1'b1;
      else                     pcnt <= '0;
      if (polling && tmo_hit) err <= 1'b1;
    end
  end
`else
  assign poll_go = !din[7];
  assign err     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    part_nx  = part_q;
    reg_nx   = reg_q;
    val_nx   = val_q;
    gnt_nx   = gnt;
    cs_nx    = cs_n;
    wr_nx    = wr_n;
    addr_nx  = addr;
    dout_nx  = dout;
    unique case (state)
      IDLE: begin
        cs_nx = 1'b1;
        wr_nx = 1'b1;
        if (req0 || req1) begin
          state_nx = POLL_A;
          gnt_nx   = sel;
          part_nx  = sel_part;
          reg_nx   = sel ? reg1 : reg0;
          val_nx   = sel ? val1 : val0;
          addr_nx  = {sel_part, 1'b0};
          cs_nx    = 1'b0;
        end
      end
      POLL_A, POLL_V: begin
        if (poll_go) begin
          state_nx = (state == POLL_A) ? STRB_A : STRB_V;
          cs_nx    = 1'b0;
          wr_nx    = 1'b0;
          cnt_nx   = STRB_LAST;
          dout_nx  = (state == POLL_A) ? reg_q : val_q;
          addr_nx  = {part_q, state == POLL_V};
        end
      end
      STRB_A, STRB_V: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          cs_nx = 1'b1;
          wr_nx = 1'b1;
          if (GAP != 0) begin
            state_nx = (state == STRB_A) ? HOLD_A : HOLD_V;
            cnt_nx   = GAP_LAST;
          end else if (state == STRB_A) begin
            state_nx = POLL_V;
            cs_nx    = 1'b0;
          end else begin
            state_nx = ACK;
          end
        end
      end
      HOLD_A, HOLD_V: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 1'b1;
        end else if (state == HOLD_A) begin
          state_nx = POLL_V;
          cs_nx    = 1'b0;
        end else begin
          state_nx = ACK;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      part_q <= 1'b0;
      reg_q  <= 8'd0;
      val_q  <= 8'd0;
      gnt    <= 1'b1;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      addr   <= 2'd0;
      dout   <= 8'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      part_q <= part_nx;
      reg_q  <= reg_nx;
      val_q  <= val_nx;
      gnt    <= gnt_nx;
      cs_n   <= cs_nx;
      wr_n   <= wr_nx;
      addr   <= addr_nx;
      dout   <= dout_nx;
    end
  end

  assign ack0 = (state == ACK) && !gnt;
  assign ack1 = (state == ACK) && gnt;

endmodule

// File: tb/tb_jt12_wr_arb.sv
// tb_jt12_wr_arb: random + directed bench for jt12_wr_arb.
// A procedural transaction model predicts every output each cycle.

module tb_jt12_wr_arb;

  localparam int WR_CYC = 2;
  localparam int GAP    = 1;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, part0 = 1'b0;
  logic       req1 = 1'b0, part1 = 1'b0;
  logic [7:0] reg0 = 8'd0, val0 = 8'd0;
  logic [7:0] reg1 = 8'd0, val1 = 8'd0;
  logic [7:0] din = 8'd0;
  logic       ack0, ack1, cs_n, wr_n, gnt, err;
  logic [1:0] addr;
  logic [7:0] dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  jt12_wr_arb #(
    .WR_CYC(WR_CYC),
    .GAP   (GAP),
    .TMO   (TMO)
  ) dut (
    .rst  (rst),
    .clk  (clk),
    .req0 (req0),
    .part0(part0),
    .reg0 (reg0),
    .val0 (val0),
    .ack0 (ack0),
    .req1 (req1),
    .part1(part1),
    .reg1 (reg1),
    .val1 (val1),
    .ack1 (ack1),
    .cs_n (cs_n),
    .wr_n (wr_n),
    .addr (addr),
    .dout (dout),
    .din  (din),
    .gnt  (gnt),
    .err  (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       e_cs_n, e_wr_n, e_ack0, e_ack1, e_gnt, e_err;
  logic [1:0] e_addr;
  logic [7:0] e_dout;
  bit         ab;

  function automatic void m_reset();
    e_cs_n = 1'b1; e_wr_n = 1'b1;
    e_ack0 = 1'b0; e_ack1 = 1'b0;
    e_gnt  = 1'b1; e_err  = 1'b0;
    e_addr = 2'd0; e_dout = 8'd0;
  endfunction

  task automatic m_edge();
    @(posedge clk);
    if (rst) begin
      ab = 1'b1;
      m_reset();
    end
  endtask

  task automatic m_poll();
    int n = 0;
    forever begin
      m_edge();
      if (ab) return;
      n++;
      if (!din[7]) return;
`ifdef JT12_ARB_TIMEOUT_EN
      if (n >= TMO) begin
        e_err = 1'b1;
        return;
      end
`endif
    end
  endtask

  task automatic m_write(input logic [1:0] a, input logic [7:0] d);
    m_poll();
    if (ab) return;
    e_addr = a; e_dout = d;
    e_cs_n = 1'b0; e_wr_n = 1'b0;
    repeat (WR_CYC) begin
      m_edge();
      if (ab) return;
    end
    e_cs_n = 1'b1; e_wr_n = 1'b1;
    repeat (GAP) begin
      m_edge();
      if (ab) return;
    end
  endtask

  initial begin
    logic g, p;
    logic [7:0] r, v;
    m_reset();
    forever begin
      ab = 1'b0;
      m_edge();
      if (ab) continue;
      if (!(req0 || req1)) continue;
      g = (req0 && req1) ? !e_gnt : req1;
      p = g ? part1 : part0;
      r = g ? reg1 : reg0;
      v = g ? val1 : val0;
      e_gnt = g; e_addr = {p, 1'b0}; e_cs_n = 1'b0;
      m_write({p, 1'b0}, r);
      if (ab) continue;
      e_cs_n = 1'b0;
      m_write({p, 1'b1}, v);
      if (ab) continue;
      if (g) e_ack1 = 1'b1;
      else   e_ack0 = 1'b1;
      m_edge();
      if (!ab) begin
        e_ack0 = 1'b0; e_ack1 = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cs_n", cs_n, e_cs_n);
      chk("wr_n", wr_n, e_wr_n);
      chk("addr", addr, e_addr);
      chk("dout", dout, e_dout);
      chk("ack0", ack0, e_ack0);
      chk("ack1", ack1, e_ack1);
      chk("gnt", gnt, e_gnt);
      chk("err", err, e_err);
      chk("ack_excl", ack0 & ack1, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin(input string nm, input logic [7:0] d,
                     input logic [7:0] m, input logic [7:0] lit);
    chk(nm, d, lit);
    chk({"model_", nm}, m, lit);
  endtask

  task automatic wait_ack(input bit which, input int lim,
                          input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      nedge(1);
      if ((which ? ack1 : ack0) === 1'b1) seen = 1'b1;
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    int n;
    int order [4];
    int rr_exp [4];
    rr_exp = '{0, 1, 0, 1};

    nedge(3);
    pin("rst_cs_n", cs_n, e_cs_n, 1);
    pin("rst_wr_n", wr_n, e_wr_n, 1);
    pin("rst_gnt", gnt, e_gnt, 1);
    pin("rst_addr", addr, e_addr, 0);
    pin("rst_dout", dout, e_dout, 0);
    pin("rst_err", err, e_err, 0);
    rst = 1'b0;

    // single write, dropped req and changed inputs after grant
    part0 = 1'b1; reg0 = 8'h28; val0 = 8'hF0; req0 = 1'b1;
    nedge(1);
    req0 = 1'b0; reg0 = 8'h00; val0 = 8'h00; part0 = 1'b0;
    nedge(1);
    pin("s1_wr_n", wr_n, e_wr_n, 0);
    pin("s1_addr", addr, e_addr, 2'b10);
    pin("s1_dout", dout, e_dout, 8'h28);
    nedge(1);
    pin("s1_wr_n_2nd", wr_n, e_wr_n, 0);
    nedge(1);
    pin("s1_end", wr_n, e_wr_n, 1);
    nedge(2);
    pin("s2_wr_n", wr_n, e_wr_n, 0);
    pin("s2_addr", addr, e_addr, 2'b11);
    pin("s2_dout", dout, e_dout, 8'hF0);
    nedge(2);
    pin("ack0_early", ack0, e_ack0, 0);
    nedge(1);
    pin("ack0_n9", ack0, e_ack0, 1);
    pin("ack0_gnt", gnt, e_gnt, 0);
    nedge(1);
    pin("ack0_pulse", ack0, e_ack0, 0);

    // round robin with both held
    rst = 1'b1; nedge(1); rst = 1'b0;
    part0 = 1'b0; reg0 = 8'hA0; val0 = 8'h01;
    part1 = 1'b1; reg1 = 8'hB4; val1 = 8'hC0;
    req0 = 1'b1; req1 = 1'b1;
    n = 0;
    order = '{-1, -1, -1, -1};
    for (int i = 0; i < 200 && n < 4; i++) begin
      nedge(1);
      if (ack0 || ack1) begin
        order[n] = ack1 ? 1 : 0;
        n++;
        if (n == 4) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_count", n, 4);
    for (int i = 0; i < 4; i++) chk("rr_order", order[i], rr_exp[i]);
    nedge(2);

    // busy stall of 20 cycles in the value poll
    part0 = 1'b0; reg0 = 8'h30; val0 = 8'h71; req0 = 1'b1;
    nedge(1);
    req0 = 1'b0;
    nedge(4);
    din = 8'h80;
    for (int i = 0; i < 20; i++) begin
      nedge(1);
      chk("stall_cs_n", cs_n, 0);
      chk("stall_wr_n", wr_n, 1);
    end
    din = 8'h00;
    nedge(1);
    pin("stall_strobe", wr_n, e_wr_n, 0);
    pin("stall_addr", addr, e_addr, 2'b01);
    pin("stall_dout", dout, e_dout, 8'h71);
    nedge(2);
    pin("stall_ack_early", ack0, e_ack0, 0);
    nedge(1);
    pin("stall_ack", ack0, e_ack0, 1);
    nedge(2);

    // reset in the middle of the address strobe
    part1 = 1'b1; reg1 = 8'h40; val1 = 8'h7F; req1 = 1'b1;
    nedge(2);
    pin("mid_strobe", wr_n, e_wr_n, 0);
    rst = 1'b1; req0 = 1'b1;
    nedge(1);
    pin("abort_cs_n", cs_n, e_cs_n, 1);
    pin("abort_wr_n", wr_n, e_wr_n, 1);
    pin("abort_ack1", ack1, e_ack1, 0);
    rst = 1'b0;
    nedge(1);
    pin("post_rst_gnt", gnt, e_gnt, 0);
    req0 = 1'b0;
    wait_ack(1'b0, 60, "post_rst_ack0");
    wait_ack(1'b1, 60, "post_rst_ack1");
    req1 = 1'b0;
    nedge(2);

`ifdef JT12_ARB_TIMEOUT_EN
    // busy stuck high: both polls time out
    din = 8'h80; part0 = 1'b0; req0 = 1'b1;
    nedge(1);
    req0 = 1'b0;
    nedge(15);
    pin("tmo_err_early", err, e_err, 0);
    pin("tmo_wait", wr_n, e_wr_n, 1);
    nedge(1);
    pin("tmo_err", err, e_err, 1);
    pin("tmo_strobe", wr_n, e_wr_n, 0);
    wait_ack(1'b0, 100, "tmo_ack0");
    rst = 1'b1;
    nedge(1);
    pin("tmo_err_clr", err, e_err, 0);
    rst = 1'b0; din = 8'h00;
    nedge(2);
`endif

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      nedge(1);
      if (ack0) req0 = 1'($urandom_range(0, 1));
      else if (!req0) req0 = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 59) == 0) req0 = 1'b0;
      if (ack1) req1 = 1'($urandom_range(0, 1));
      else if (!req1) req1 = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 59) == 0) req1 = 1'b0;
      part0 = 1'($urandom); reg0 = 8'($urandom); val0 = 8'($urandom);
      part1 = 1'($urandom); reg1 = 8'($urandom); val1 = 8'($urandom);
      din = {($urandom_range(0, 3) == 0), 7'($urandom)};
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; din = 8'h00;
    nedge(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
